trace_commit_buffer: RTL and testbench

Captures every retired instruction from the CPU write-back stage, together with its register write, load/store and CSR side effects, into a fixed-format trace record, and buffers the records in a FIFO for a downstream consumer (host DPI drain or trace UART) over a valid/ready stream. Sits directly downstream of the SoC testbench top and consumes its WB-stage trace outputs. Provides drop accounting on overflow and an orderly drain when the program requests exit.

---
 rtl/trace_pkg.sv | 52 +++++
 rtl/sync_fifo.sv | 81 ++++++++
 rtl/trace_commit_buffer.sv | 169 ++++++++++++++++
 tb/tb_trace_commit_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retired-instruction trace buffer: record layout,
// side-effect kind encoding, capture FSM states and the kind classifier.
package trace_pkg;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_CSR   = 2'd3
  } trace_kind_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_e;

  // Field order is MSB first; consumers decode by casting to this struct.
  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd_data;
    logic [4:0]  rd;
    logic        rd_we;
    trace_kind_e kind;
    logic [31:0] side_addr;
    logic [31:0] side_data;
    logic        gap;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

  // A CSR access wins over memory; a store wins over a load.
  function automatic trace_kind_e classify(input logic csr_valid,
                                           input logic mem_valid,
                                           input logic mem_write,
                                           input logic mem_read);
    trace_kind_e k;
    if (csr_valid) begin
      k = KIND_CSR;
    end else if (mem_valid && mem_write) begin
      k = KIND_STORE;
    end else if (mem_valid && mem_read) begin
      k = KIND_LOAD;
    end else begin
      k = KIND_NONE;
    end
    return k;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head output: dout always holds the
// oldest entry (zero when empty), so a push into an empty FIFO becomes
// visible on the following cycle without combinational fall-through.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  logic             pop_fire;
  logic             push_fire;
  logic [AW-1:0]    rd_next;
  logic [LW-1:0]    level_next;
  logic [WIDTH-1:0] head_next;

  // Handshake qualification and next-state of pointers, count and head.
  always_comb begin
    pop_fire   = pop && !empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    push_fire  = push && (!full || pop_fire);
    rd_next    = rd_ptr;
    level_next = level + LW'(push_fire) - LW'(pop_fire);
    if (pop_fire) begin
      rd_next = rd_ptr + AW'(1);
    end else begin
      rd_next = rd_ptr;
    end
    if (level_next == LW'(0)) begin
      head_next = '0;
    end else if (push_fire && (wr_ptr == rd_next)) begin
      head_next = din;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // Storage array write; contents need no reset because level gates reads.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy, flags and the registered head record.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (push_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      level  <= level_next;
      full   <= (level_next == LW'(DEPTH));
      empty  <= (level_next == LW'(0));
      dout   <= head_next;
    end
  end

endmodule

// File: rtl/trace_commit_buffer.sv
// Formats each retired instruction into a trace record, queues it for a
// valid/ready consumer, accounts for overflow drops and drains on exit.
module trace_commit_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_instr_retired,
  input  logic [31:0]              wb_pc,
  input  logic [31:0]              wb_instr,
  input  logic                     wb_rd_write,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_rd_data,
  input  logic                     mem_valid,
  input  logic                     mem_write,
  input  logic                     mem_read,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     csr_valid,
  input  logic [11:0]              csr_addr,
  input  logic [31:0]              csr_wdata,
  input  logic                     exit_request,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TRACE_REC_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     trace_done
);

  trace_state_e     state;
  trace_state_e     state_next;
  logic [31:0]      seq;
  logic             gap_pending;

  logic             fifo_full;
  logic             fifo_empty;
  logic             retire_run;
  logic             pop_fire;
  logic             accept;
  logic             drop;
  trace_rec_t       rec;

  // Saturating increment for the drop counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // Retire qualification: only RUN captures; a full FIFO drops unless it pops.
  always_comb begin
    retire_run = wb_instr_retired && (state == ST_RUN);
    pop_fire   = out_valid && out_ready;
    accept     = retire_run && (!fifo_full || pop_fire);
    drop       = retire_run && fifo_full && !pop_fire;
  end

  // Build the trace record from the write-back side-effect signals.
  always_comb begin
    rec         = '0;
    rec.seq     = seq;
    rec.pc      = wb_pc;
    rec.instr   = wb_instr;
    rec.rd      = wb_rd;
    rec.rd_we   = wb_rd_write;
    rec.gap     = gap_pending;
    if (wb_rd_write) begin
      rec.rd_data = wb_rd_data;
    end else begin
      rec.rd_data = 32'd0;
    end
    rec.kind = classify(csr_valid, mem_valid, mem_write, mem_read);
    case (rec.kind)
      KIND_CSR: begin
        rec.side_addr = {20'd0, csr_addr};
        rec.side_data = csr_wdata;
      end
      KIND_STORE: begin
        rec.side_addr = mem_addr;
        rec.side_data = mem_wdata;
      end
      KIND_LOAD: begin
        rec.side_addr = mem_addr;
        rec.side_data = mem_rdata;
      end
      default: begin
        rec.side_addr = 32'd0;
        rec.side_data = 32'd0;
      end
    endcase
  end

  // Capture FSM: RUN until exit, DRAIN until the FIFO is empty, then DONE.
  always_comb begin
    case (state)
      ST_RUN: begin
        if (exit_request) begin
          state_next = ST_DRAIN;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State, sequence number, drop accounting, gap flag and done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      seq         <= 32'd0;
      drop_count  <= '0;
      gap_pending <= 1'b0;
      trace_done  <= 1'b0;
    end else begin
      state      <= state_next;
      trace_done <= (state_next == ST_DONE);
      // Dropped retires still consume a sequence number so gaps are visible.
      if (retire_run) begin
        seq <= seq + 32'd1;
      end
      if (drop) begin
        drop_count  <= sat_inc(drop_count);
        gap_pending <= 1'b1;
      end else if (accept) begin
        gap_pending <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (rec),
    .pop   (pop_fire),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_trace_commit_buffer.sv
// Directed bench for trace_commit_buffer with hand-computed expectations.
module tb_trace_commit_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   wb_instr_retired = 1'b0;
  logic [31:0]            wb_pc = 32'd0;
  logic [31:0]            wb_instr = 32'd0;
  logic                   wb_rd_write = 1'b0;
  logic [4:0]             wb_rd = 5'd0;
  logic [31:0]            wb_rd_data = 32'd0;
  logic                   mem_valid = 1'b0;
  logic                   mem_write = 1'b0;
  logic                   mem_read = 1'b0;
  logic [31:0]            mem_addr = 32'd0;
  logic [31:0]            mem_wdata = 32'd0;
  logic [31:0]            mem_rdata = 32'd0;
  logic                   csr_valid = 1'b0;
  logic [11:0]            csr_addr = 12'd0;
  logic [31:0]            csr_wdata = 32'd0;
  logic                   exit_request = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [TRACE_REC_W-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       drop_count;
  logic                   trace_done;

  trace_rec_t rec;
  int n_checks = 0;
  int n_fail = 0;

  assign rec = trace_rec_t'(out_data);

  trace_commit_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .wb_instr_retired(wb_instr_retired), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_rd_write(wb_rd_write), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .exit_request(exit_request),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .drop_count(drop_count), .trace_done(trace_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one retire pulse for a single cycle, then return inputs to idle.
  task automatic drive_retire(input logic [31:0] pc, input logic [31:0] instr,
                              input logic we, input logic [4:0] rd, input logic [31:0] rdd,
                              input logic mv, input logic mw, input logic mr,
                              input logic [31:0] ma, input logic [31:0] mwd, input logic [31:0] mrd,
                              input logic cv, input logic [11:0] ca, input logic [31:0] cwd);
    wb_instr_retired = 1'b1;
    wb_pc = pc; wb_instr = instr;
    wb_rd_write = we; wb_rd = rd; wb_rd_data = rdd;
    mem_valid = mv; mem_write = mw; mem_read = mr;
    mem_addr = ma; mem_wdata = mwd; mem_rdata = mrd;
    csr_valid = cv; csr_addr = ca; csr_wdata = cwd;
    tick();
    wb_instr_retired = 1'b0;
    wb_pc = 32'd0; wb_instr = 32'd0;
    wb_rd_write = 1'b0; wb_rd = 5'd0; wb_rd_data = 32'd0;
    mem_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    mem_addr = 32'd0; mem_wdata = 32'd0; mem_rdata = 32'd0;
    csr_valid = 1'b0; csr_addr = 12'd0; csr_wdata = 32'd0;
  endtask

  // Plain ALU retire with a recognisable pc.
  task automatic simple_retire(input logic [31:0] pc);
    drive_retire(pc, 32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                 32'd0, 32'd0, 32'd0, 1'b0, 12'd0, 32'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data_zero", 32'(out_data == '0), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_done", 32'(trace_done), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // ADDI x5, x0, 42
    drive_retire(32'h8000_0000, 32'h02A0_0293, 1'b1, 5'd5, 32'h2A, 1'b0, 1'b0, 1'b0,
                 32'd0, 32'd0, 32'd0, 1'b0, 12'd0, 32'd0);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_level", 32'(level), 32'd1);
    check("addi_seq", rec.seq, 32'd0);
    check("addi_pc", rec.pc, 32'h8000_0000);
    check("addi_instr", rec.instr, 32'h02A0_0293);
    check("addi_kind", 32'(rec.kind), 32'd0);
    check("addi_rd_we", 32'(rec.rd_we), 32'd1);
    check("addi_rd", 32'(rec.rd), 32'd5);
    check("addi_rd_data", rec.rd_data, 32'h2A);
    check("addi_side_addr", rec.side_addr, 32'd0);
    check("addi_gap", 32'(rec.gap), 32'd0);
    tick();
    check("addi_popped", 32'(out_valid), 32'd0);

    // SW then LW, held back so both queue
    out_ready = 1'b0;
    drive_retire(32'h8000_0004, 32'h0011_2023, 1'b0, 5'd0, 32'h55, 1'b1, 1'b1, 1'b0,
                 32'h1000, 32'hDEAD_BEEF, 32'h999, 1'b0, 12'd0, 32'd0);
    drive_retire(32'h8000_0008, 32'h0040_2303, 1'b1, 5'd6, 32'h1234, 1'b1, 1'b0, 1'b1,
                 32'h1004, 32'h777, 32'h1234, 1'b0, 12'd0, 32'd0);
    check("swlw_level", 32'(level), 32'd2);
    check("sw_seq", rec.seq, 32'd1);
    check("sw_kind", 32'(rec.kind), 32'd2);
    check("sw_addr", rec.side_addr, 32'h1000);
    check("sw_data", rec.side_data, 32'hDEAD_BEEF);
    check("sw_rd_data_forced", rec.rd_data, 32'd0);
    out_ready = 1'b1;
    tick();
    check("lw_seq", rec.seq, 32'd2);
    check("lw_kind", 32'(rec.kind), 32'd1);
    check("lw_addr", rec.side_addr, 32'h1004);
    check("lw_data", rec.side_data, 32'h1234);
    check("lw_rd_data", rec.rd_data, 32'h1234);
    tick();
    check("lw_popped", 32'(level), 32'd0);

    // CSRRW mstatus with mem_valid also asserted
    drive_retire(32'h8000_000C, 32'h3000_93F3, 1'b1, 5'd7, 32'h1800, 1'b1, 1'b1, 1'b0,
                 32'h2000, 32'h4444, 32'd0, 1'b1, 12'h300, 32'h8);
    check("csr_seq", rec.seq, 32'd3);
    check("csr_kind", 32'(rec.kind), 32'd3);
    check("csr_addr", rec.side_addr, 32'h300);
    check("csr_data", rec.side_data, 32'h8);
    tick();

    // Overflow: DEPTH+3 retires with consumer stalled (reset mid-stream first)
    out_ready = 1'b0;
    simple_retire(32'h8000_0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < DEPTH + 3; i++) simple_retire(32'(i * 4));
    check("ovf_level", 32'(level), 32'(DEPTH));
    check("ovf_drop", 32'(drop_count), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovf_seq%0d", i), rec.seq, 32'(i));
      tick();
    end
    check("ovf_drained", 32'(level), 32'd0);
    simple_retire(32'h9000_0000);
    check("gap_seq", rec.seq, 32'(DEPTH + 3));
    check("gap_set", 32'(rec.gap), 32'd1);
    tick();
    simple_retire(32'h9000_0004);
    check("gap_clear_seq", rec.seq, 32'(DEPTH + 4));
    check("gap_clear", 32'(rec.gap), 32'd0);
    tick();

    // Full FIFO with retire and pop in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) simple_retire(32'hA000_0000 + 32'(i * 4));
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_head_seq", rec.seq, 32'd21);
    out_ready = 1'b1;
    simple_retire(32'hA000_1000);
    check("pushpop_level", 32'(level), 32'(DEPTH));
    check("pushpop_drop", 32'(drop_count), 32'd3);
    check("pushpop_head", rec.seq, 32'd22);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        check("pushpop_tail_seq", rec.seq, 32'd37);
        check("pushpop_tail_pc", rec.pc, 32'hA000_1000);
      end
      tick();
    end
    check("pushpop_drained", 32'(level), 32'd0);

    // Exit with concurrent retire, then drain to DONE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) simple_retire(32'hB000_0000 + 32'(i * 4));
    exit_request = 1'b1;
    simple_retire(32'hB000_000C);
    exit_request = 1'b0;
    check("exit_level", 32'(level), 32'd4);
    simple_retire(32'hB000_0010);
    check("drain_ignore_level", 32'(level), 32'd4);
    check("drain_ignore_drop", 32'(drop_count), 32'd0);
    check("drain_not_done", 32'(trace_done), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_seq%0d", i), rec.seq, 32'(i));
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check("done_not_yet", 32'(trace_done), 32'd0);
    tick();
    check("done_set", 32'(trace_done), 32'd1);
    simple_retire(32'hB000_0014);
    check("done_ignore", 32'(level), 32'd0);
    check("done_hold", 32'(trace_done), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("final_rst_done", 32'(trace_done), 32'd0);
    check("final_rst_level", 32'(level), 32'd0);
    simple_retire(32'hC000_0000);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_seq", rec.seq, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
